ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high (RstEnable = 1).
REQ-003 SHALL have port if_req_i  input  1  instruction-fetch request, held high until if_ack_o.
REQ-004 SHALL have port if_addr_i  input  32  fetch byte address (InstAddrBus).
REQ-005 SHALL have port if_inst_o  output  32  fetched instruction (InstBus).
REQ-006 SHALL have port if_ack_o  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port d_req_i  input  1  data request, held high until d_ack_o.
REQ-008 SHALL have port d_we_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port d_addr_i  input  32  data byte address.
REQ-010 SHALL have port d_sel_i  input  4  byte-lane enables.
REQ-011 SHALL have port d_wdata_i  input  32  write data.
REQ-012 SHALL have port d_rdata_o  output  32  read data.
REQ-013 SHALL have port d_ack_o  output  1  one-cycle data completion pulse.
REQ-014 SHALL have port stallreq_o  output  1  pipeline stall request to ctrl.
REQ-015 SHALL have ports mem_ce_o (1), mem_we_o (1), mem_addr_o (32), mem_sel_o (4), mem_wdata_o (32) as outputs and mem_rdata_i (32) as input, to a single-port synchronous RAM with one-cycle read latency.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT_IF, GRANT_D, RESP_IF, RESP_D.
REQ-017 SHALL, in IDLE, go to GRANT_D if d_req_i, else GRANT_IF if if_req_i, else stay (fixed priority, data first).
REQ-018 SHALL, in GRANT_x, drive mem_ce_o = 1 with the granted requester's address/sel/we/wdata (fetch: we = 0, sel = 4'b1111), then go to RESP_x unconditionally.
REQ-019 SHALL, in RESP_x, pulse the matching ack for exactly one cycle with if_inst_o/d_rdata_o = mem_rdata_i (combinational pass-through), then arbitrate as in IDLE in the same cycle, giving back-to-back grants without an idle bubble.
REQ-020 SHALL give 2-cycle latency: request seen in state IDLE/RESP at edge k -> GRANT at cycle k+1 -> ack at cycle k+2.
REQ-021 SHALL ack writes in RESP_D identically to reads; d_rdata_o = 0 on write ack.
REQ-022 SHALL hold all mem_* outputs at 0 (mem_ce_o = 0) outside GRANT states.
REQ-023 SHALL drive stallreq_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o).
REQ-024 SHALL drive if_inst_o and d_rdata_o to 0 when their ack is low.
REQ-025 SHALL, if a requester drops req while in GRANT/RESP, still complete the access and pulse ack (ignored upstream); no abort.
REQ-026 SHALL latch the granted request fields at the transition into GRANT_x; input changes during GRANT/RESP do not affect the current access.

Reset
REQ-027 SHALL, while rst = 1 at a clock edge, enter IDLE and clear the priority/grant registers.
REQ-028 SHALL force all outputs to 0 while in reset, including stallreq_o, whatever the requests are.
REQ-029 SHALL abandon any in-flight access when reset is asserted mid-operation; no ack for it afterwards.

Configuration
REQ-030 SHALL, with RAM_ARB_ROUND_ROBIN_EN defined, use a 1-bit last-grant register: when both request together, grant the one not served last; single requests are granted directly.
REQ-031 SHALL, without RAM_ARB_ROUND_ROBIN_EN, use the fixed data-first priority of REQ-017 and contain no last-grant register.

Verification
REQ-032 SHALL cover: reset then if_req_i = 1, if_addr_i = 0x00000004 -> mem_ce_o = 1, mem_addr_o = 0x4 in cycle 1; if_ack_o = 1, if_inst_o = RAM[1] in cycle 2.
REQ-033 SHALL cover: d_req_i = 1, d_we_i = 1, addr 0x10, sel 4'b0011, wdata 0xDEADBEEF -> one mem write with sel 0011; a following read of 0x10 returns 0x0000BEEF (RAM initially 0).
REQ-034 SHALL cover: if_req_i and d_req_i both held from cycle 0 -> fixed mode: d_ack_o in cycle 2, if_ack_o in cycle 4; round-robin mode: grants alternate, starting with data after reset.
REQ-035 SHALL cover: continuous fetch requests to 0x0, 0x4, 0x8 -> if_ack_o in cycles 2, 4, 6; stallreq_o low only in ack cycles.
REQ-036 SHALL cover: rst = 1 in the GRANT_D cycle of a write -> no d_ack_o, all outputs 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Requester-side and memory-side signals of the fetch/data RAM arbiter.
// The arbiter takes the slave view; the requesters and the RAM model take the master view.
interface ram_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_inst_o;
    logic        if_ack_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        stallreq_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_sel_i, d_wdata_i, mem_rdata_i,
        output if_inst_o, if_ack_o, d_rdata_o, d_ack_o, stallreq_o,
               mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_sel_i, d_wdata_i, mem_rdata_i,
        input  if_inst_o, if_ack_o, d_rdata_o, d_ack_o, stallreq_o,
               mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o
    );
endinterface

// File: rtl/ram_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port synchronous RAM (RAM_ARB_ROUND_ROBIN_EN selects round-robin).
// Latency: grant one cycle after the request is seen, one-cycle ack the cycle after; back-to-back grants from the ack cycle.
// Backpressure: requesters hold req until ack; stallreq_o holds the pipeline while any request is outstanding.
module ram_arbiter (
    input  logic           clk,
    input  logic           rst,
    ram_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANT_IF = 3'd1,
        GRANT_D  = 3'd2,
        RESP_IF  = 3'd3,
        RESP_D   = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_mem_ce;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_sel;
    logic [31:0] r_mem_wdata;
    logic        r_if_ack;
    logic        r_d_ack;
    logic        r_d_we;
    logic        w_pick_d;
    logic        w_pick_if;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // 1 = data was the last requester served; cleared so data wins the first tie after reset.
    logic        r_last_d;

    always_comb begin
        w_pick_d  = bus.d_req_i & (~bus.if_req_i | ~r_last_d);
        w_pick_if = bus.if_req_i & ~w_pick_d;
    end
`else
    always_comb begin
        w_pick_d  = bus.d_req_i;
        w_pick_if = bus.if_req_i & ~bus.d_req_i;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_ce    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_sel   <= 4'h0;
            r_mem_wdata <= 32'h0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_d_we      <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            r_last_d    <= 1'b0;
`endif
        end else begin
            r_mem_ce    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_sel   <= 4'h0;
            r_mem_wdata <= 32'h0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            case (r_state)
                GRANT_IF: begin
                    r_state  <= RESP_IF;
                    r_if_ack <= 1'b1;
                end
                GRANT_D: begin
                    r_state <= RESP_D;
                    r_d_ack <= 1'b1;
                end
                default: begin
                    // IDLE and both RESP states arbitrate, so a new grant follows an ack directly.
                    if (w_pick_d) begin
                        r_state     <= GRANT_D;
                        r_mem_ce    <= 1'b1;
                        r_mem_we    <= bus.d_we_i;
                        r_mem_addr  <= bus.d_addr_i;
                        r_mem_sel   <= bus.d_sel_i;
                        r_mem_wdata <= bus.d_wdata_i;
                        r_d_we      <= bus.d_we_i;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                        r_last_d    <= 1'b1;
`endif
                    end else if (w_pick_if) begin
                        r_state     <= GRANT_IF;
                        r_mem_ce    <= 1'b1;
                        r_mem_addr  <= bus.if_addr_i;
                        r_mem_sel   <= 4'hF;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                        r_last_d    <= 1'b0;
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs are masked by rst so nothing leaks out during the reset cycle itself.
    assign bus.mem_ce_o    = r_mem_ce & ~rst;
    assign bus.mem_we_o    = r_mem_we & ~rst;
    assign bus.mem_addr_o  = r_mem_addr & {32{~rst}};
    assign bus.mem_sel_o   = r_mem_sel & {4{~rst}};
    assign bus.mem_wdata_o = r_mem_wdata & {32{~rst}};
    assign bus.if_ack_o    = r_if_ack & ~rst;
    assign bus.d_ack_o     = r_d_ack & ~rst;
    assign bus.if_inst_o   = bus.if_ack_o ? bus.mem_rdata_i : 32'h0;
    assign bus.d_rdata_o   = (bus.d_ack_o & ~r_d_we) ? bus.mem_rdata_i : 32'h0;
    assign bus.stallreq_o  = ~rst & ((bus.if_req_i & ~bus.if_ack_o) | (bus.d_req_i & ~bus.d_ack_o));

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a one-cycle synchronous RAM model; honours RAM_ARB_ROUND_ROBIN_EN.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;
    int   k;

    always #5 clk = ~clk;

    ram_arbiter_if bus();

    ram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ram [0:63];

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h0 : 32'h1000_0000 + 32'(i) * 32'h11;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else if (bus.mem_ce_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_sel_o[b]) ram[bus.mem_addr_o[7:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
            end
            bus.mem_rdata_i <= ram[bus.mem_addr_o[7:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [3:0] ds, input logic [31:0] dwd);
        bus.if_req_i  = ir;
        bus.if_addr_i = ia;
        bus.d_req_i   = dr;
        bus.d_we_i    = dw;
        bus.d_addr_i  = da;
        bus.d_sel_i   = ds;
        bus.d_wdata_i = dwd;
    endtask

    task automatic reset_pulse();
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.mem_rdata_i = 32'h0;
        drive(1, 32'h4, 1, 1, 32'h10, 4'hF, 32'h1234_5678);

        // Reset with both requests high: everything stays 0.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_stall", 32'(bus.stallreq_o), 0);
            chk("rst_ce", 32'(bus.mem_ce_o), 0);
            chk("rst_acks", 32'({bus.if_ack_o, bus.d_ack_o}), 0);
        end

        // Single fetch of 0x4.
        tick();
        rst = 1'b0;
        drive(1, 32'h4, 0, 0, 0, 0, 0);
        #1;
        chk("f_c0_stall", 32'(bus.stallreq_o), 1);
        chk("f_c0_ack", 32'(bus.if_ack_o), 0);
        tick();
        chk("f_c1_ce", 32'(bus.mem_ce_o), 1);
        chk("f_c1_addr", bus.mem_addr_o, 32'h4);
        chk("f_c1_sel", 32'(bus.mem_sel_o), 32'hF);
        chk("f_c1_we", 32'(bus.mem_we_o), 0);
        tick();
        chk("f_c2_ack", 32'(bus.if_ack_o), 1);
        chk("f_c2_inst", bus.if_inst_o, 32'h1000_0011);
        chk("f_c2_stall", 32'(bus.stallreq_o), 0);
        chk("f_c2_ce", 32'(bus.mem_ce_o), 0);
        bus.if_req_i = 1'b0;
        tick();
        chk("f_c3_ack", 32'(bus.if_ack_o), 0);
        chk("f_c3_inst", bus.if_inst_o, 0);

        // Partial write then read back of 0x10.
        tick();
        drive(0, 0, 1, 1, 32'h10, 4'b0011, 32'hDEAD_BEEF);
        tick();
        chk("w_ce", 32'(bus.mem_ce_o), 1);
        chk("w_we", 32'(bus.mem_we_o), 1);
        chk("w_sel", 32'(bus.mem_sel_o), 32'h3);
        chk("w_addr", bus.mem_addr_o, 32'h10);
        chk("w_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
        bus.d_wdata_i = 32'h0;
        tick();
        chk("w_ack", 32'(bus.d_ack_o), 1);
        chk("w_rdata0", bus.d_rdata_o, 0);
        drive(0, 0, 1, 0, 32'h10, 4'hF, 0);
        tick();
        chk("r_ce", 32'(bus.mem_ce_o), 1);
        chk("r_we", 32'(bus.mem_we_o), 0);
        chk("r_noack", 32'(bus.d_ack_o), 0);
        tick();
        chk("r_ack", 32'(bus.d_ack_o), 1);
        chk("r_rdata", bus.d_rdata_o, 32'h0000_BEEF);
        bus.d_req_i = 1'b0;
        tick();
        chk("r_ack_off", 32'(bus.d_ack_o), 0);

        // Simultaneous requests, each dropped on its own ack.
        reset_pulse();
        tick();
        drive(1, 32'h8, 1, 0, 32'h4, 4'hF, 0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("both_a_c%0d", c), 32'({bus.if_ack_o, bus.d_ack_o}),
                (c == 2) ? 32'h1 : (c == 4) ? 32'h2 : 32'h0);
            if (c == 2) begin
                chk("both_a_drd", bus.d_rdata_o, 32'h1000_0011);
                bus.d_req_i = 1'b0;
            end
            if (c == 4) begin
                chk("both_a_inst", bus.if_inst_o, 32'h1000_0022);
                bus.if_req_i = 1'b0;
            end
        end

        // Both held continuously: data always wins, or alternation in round-robin mode.
        tick();
        drive(1, 32'h8, 1, 0, 32'h4, 4'hF, 0);
        for (int c = 1; c <= 8; c++) begin
            logic [1:0] exp;
            tick();
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp = (c % 4 == 2) ? 2'b01 : (c % 4 == 0) ? 2'b10 : 2'b00;
`else
            exp = (c % 2 == 0) ? 2'b01 : 2'b00;
`endif
            chk($sformatf("both_b_c%0d", c), 32'({bus.if_ack_o, bus.d_ack_o}), 32'(exp));
            if (c == 8) drive(0, 0, 0, 0, 0, 0, 0);
        end

        // Continuous fetch stream 0x0, 0x4, 0x8.
        tick();
        k = 0;
        drive(1, 32'h0, 0, 0, 0, 0, 0);
        #1;
        chk("fs_c0_stall", 32'(bus.stallreq_o), 1);
        for (int c = 1; c <= 6; c++) begin
            logic ack_exp;
            tick();
            ack_exp = (c % 2 == 0);
            chk($sformatf("fs_c%0d_ack", c), 32'(bus.if_ack_o), 32'(ack_exp));
            chk($sformatf("fs_c%0d_stall", c), 32'(bus.stallreq_o), 32'(!ack_exp));
            if (!ack_exp) begin
                chk($sformatf("fs_c%0d_addr", c), bus.mem_addr_o, 32'(4 * k));
            end else begin
                chk($sformatf("fs_c%0d_inst", c), bus.if_inst_o, init_word(k));
                k++;
                if (k == 3) bus.if_req_i = 1'b0;
                else        bus.if_addr_i = 32'(4 * k);
            end
        end

        // Reset during the grant cycle of a write abandons it.
        tick();
        drive(0, 0, 1, 1, 32'h20, 4'hF, 32'h5555_5555);
        tick();
        chk("ra_c1_ce", 32'(bus.mem_ce_o), 1);
        rst = 1'b1;
        bus.d_req_i = 1'b0;
        #1;
        chk("ra_c1_ce_rst", 32'(bus.mem_ce_o), 0);
        tick();
        chk("ra_c2_ack", 32'(bus.d_ack_o), 0);
        chk("ra_c2_ce", 32'(bus.mem_ce_o), 0);
        chk("ra_c2_we", 32'(bus.mem_we_o), 0);
        chk("ra_c2_stall", 32'(bus.stallreq_o), 0);
        rst = 1'b0;
        drive(1, 32'h8, 0, 0, 0, 0, 0);
        tick();
        chk("ra_c3_dack", 32'(bus.d_ack_o), 0);
        chk("ra_c3_ce", 32'(bus.mem_ce_o), 1);
        chk("ra_c3_addr", bus.mem_addr_o, 32'h8);
        tick();
        chk("ra_c4_ack", 32'(bus.if_ack_o), 1);
        chk("ra_c4_dack", 32'(bus.d_ack_o), 0);
        bus.if_req_i = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
